// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a LENGTH-bit word onto a UART line as LENGTH/8
// back-to-back byte frames, least-significant byte first.
//
// Frame: start bit (0), 8 data bits LSB first, optional even-parity bit,
// stop bit (1). Every bit lasts CLKS_PER_BIT clk cycles.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// (XOR of the 8 data bits) between the last data bit and the stop bit.
// Without the macro the parity state and logic do not exist.
//
// Parameters:
//   LENGTH        word width in bits, nonzero multiple of 8
//   CLKS_PER_BIT  clk cycles per UART bit, >= 2
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   transmit request, sampled only in IDLE
//   data   in   word to transmit, latched when start is accepted
//   tx     out  registered serial line, idle high
//   busy   out  high while a word is in flight
//   done   out  one-cycle pulse on the cycle the FSM re-enters IDLE

module uart_word_tx #(
    parameter int unsigned LENGTH       = 32,
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LENGTH-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NBYTES = LENGTH / 8;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    // Parameter legality is checked at elaboration time.
    if ((LENGTH == 0) || ((LENGTH % 8) != 0)) begin : g_bad_length
        $error("uart_word_tx: LENGTH must be a nonzero multiple of 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [LENGTH-1:0]   shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                last_tick;

    // Last cycle of the current bit period.
    assign last_tick = (baud_q == BAUD_LAST);

    // Next-state logic. The baud counter restarts on every transition,
    // including the per-bit advance inside DATA.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (start) begin
                    shreg_d = data;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = StStart;
                end
            end

            StStart: begin
                if (last_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end

            StData: begin
                if (last_tick) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (last_tick) begin
                    baud_d  = '0;
                    state_d = StStop;
                end
            end
`endif

            StStop: begin
                if (last_tick) begin
                    baud_d = '0;
                    // Expose the next byte in the low 8 bits.
                    shreg_d = shreg_q >> 8;
                    if (byte_q == BYTE_LAST) begin
                        byte_d  = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        // Next start bit follows the stop bit directly.
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = StStart;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                baud_d  = '0;
            end
        endcase
    end

    // tx is registered: it carries the bit belonging to the next state, so
    // the line changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shreg_d[bit_d];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = ^shreg_d[7:0];
`endif
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx (LENGTH=32, CLKS_PER_BIT=4) plus a small
// directed check of an 8-bit instance. Stimulus pushes the expected frames
// (byte value, first cycle of its start bit) and the expected busy window /
// done cycle; a negedge monitor decodes the tx line and compares.
module tb_uart_word_tx;

    localparam int unsigned C  = 4;
    localparam int unsigned NB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned B = 11;
`else
    localparam int unsigned B = 10;
`endif
    localparam int unsigned WORD_CYC = NB * B * C;

    typedef struct {
        int unsigned t0;
        logic [7:0]  b;
    } frame_t;

    typedef struct {
        int unsigned a;
        int unsigned d;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data;
    logic        tx, busy, done;
    logic        start8;
    logic [7:0]  data8;
    logic        tx8, busy8, done8;

    int unsigned cyc = 0;
    frame_t      frames[$];
    word_t       words[$];
    int          checks = 0;
    int          errors = 0;
    int          busy_err = 0;
    int unsigned next_free = 0;
    int unsigned last_a = 0;

    // Receiver state
    bit          rx_active = 1'b0;
    int unsigned rx_start;
    int unsigned off;
    int unsigned bi;
    logic [10:0] fb;
    int          glitches;
    logic        exp_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_word_tx #(
        .LENGTH(32),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .data(data),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    uart_word_tx #(
        .LENGTH(8),
        .CLKS_PER_BIT(C)
    ) dut8 (
        .clk(clk),
        .rst(rst),
        .start(start8),
        .data(data8),
        .tx(tx8),
        .busy(busy8),
        .done(done8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line level for bit position i of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge when the DUT is idle (or in its done cycle).
    task automatic send_word(input logic [31:0] d, input bit hold);
        int unsigned a;
        a = cyc + 1;
        for (int k = 0; k < NB; k++) begin
            frames.push_back('{t0: a + k * B * C, b: d[8*k +: 8]});
        end
        words.push_back('{a: a, d: a + WORD_CYC});
        next_free = a + WORD_CYC;
        last_a = a;
        start = 1'b1;
        data = d;
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            data = $urandom;
        end else begin
            wait_cyc(a + 50);
            data = 32'hFFFF_FFFF;
            wait_cyc(next_free - 5);
            start = 1'b0;
        end
    endtask

    // Monitor: busy window, done timing, tx frame decoding.
    always @(negedge clk) begin
        if (!rst) begin
            rx_active = 1'b0;
        end else begin
            exp_busy = (words.size() > 0) && (cyc >= words[0].a) && (cyc < words[0].d);
            if (busy !== exp_busy) begin
                busy_err++;
                if (busy_err <= 5) $display("busy got %0b expected %0b at cycle %0d",
                                            busy, exp_busy, cyc);
            end

            if ((words.size() > 0) && (cyc == words[0].d)) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                void'(words.pop_front());
            end else if (done !== 1'b0) begin
                check("done_spurious", {31'd0, done}, 32'd0);
            end

            if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_start = cyc;
                    fb = '1;
                    fb[0] = 1'b0;
                    glitches = 0;
                end
            end else begin
                off = cyc - rx_start;
                bi = off / C;
                if ((off % C) == 0) fb[bi] = tx;
                else if (tx !== fb[bi]) glitches++;
                if (off == B * C - 1) begin
                    rx_active = 1'b0;
                    if (frames.size() == 0) begin
                        check("frame_unexpected", rx_start, 32'hFFFF_FFFF);
                    end else begin
                        frame_t f;
                        f = frames.pop_front();
                        check("frame_start_cycle", rx_start, f.t0);
                        check("frame_byte", {24'd0, fb[8:1]}, {24'd0, f.b});
                        check("frame_stop", {31'd0, fb[B-1]}, 32'd1);
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", {31'd0, fb[9]}, {31'd0, ^f.b});
`endif
                        check("bit_hold", glitches, 0);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mis, dmis, bmis;
        rst = 1'b0;
        start = 1'b0;
        data = '0;
        start8 = 1'b0;
        data8 = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_tx8", {31'd0, tx8}, 32'd1);

        // Start requested in the very first cycle after release.
        rst = 1'b1;
        send_word(32'h1234_5678, 1'b0);
        // Start in the done cycle: back-to-back words.
        wait_cyc(next_free);
        send_word(32'h0000_00A5, 1'b0);
        // start held high, data overwritten mid-word.
        wait_cyc(next_free + 2);
        send_word(32'h1234_5678, 1'b1);
        // Bytes 07 (odd) and 03 (even).
        wait_cyc(next_free);
        send_word(32'h0000_0307, 1'b0);

        for (int i = 0; i < 8; i++) begin
            wait_cyc(next_free + $urandom_range(0, 3));
            send_word($urandom, ($urandom_range(0, 3) == 0));
        end

        // Abort mid-word.
        wait_cyc(next_free + 1);
        send_word($urandom, 1'b0);
        wait_cyc(last_a + 50);
        rst = 1'b0;
        frames.delete();
        words.delete();
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("abort_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_free = cyc;
        send_word(32'hC0FF_EE11, 1'b0);

        wait_cyc(next_free + 5);
        check("frames_drained", frames.size(), 0);
        check("words_drained", words.size(), 0);
        check("busy_trace", busy_err, 0);

        // Single-byte instance.
        start8 = 1'b1;
        data8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        data8 = 8'hAA;
        mis = 0;
        dmis = 0;
        bmis = 0;
        for (int i = 0; i < int'(B * C); i++) begin
            if (tx8 !== exp_bit(8'h55, i / int'(C))) mis++;
            if (done8 !== 1'b0) dmis++;
            if (busy8 !== 1'b1) bmis++;
            @(negedge clk);
        end
        check("len8_frame", mis, 0);
        check("len8_no_early_done", dmis, 0);
        check("len8_busy", bmis, 0);
        check("len8_done", {31'd0, done8}, 32'd1);
        check("len8_idle_tx", {31'd0, tx8}, 32'd1);
        @(negedge clk);
        check("len8_done_width", {31'd0, done8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 Parameter LENGTH, default 32: width of the word to transmit; SHALL be a nonzero multiple of 8, and any other value SHALL be an elaboration error.
REQ-002 Parameter CLKS_PER_BIT, default 5208: clk cycles per UART bit; SHALL be >= 2.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to transmit the word on data.
REQ-006 Port data  input  LENGTH  word to transmit, driven by the upstream tx-select multiplexer output.
REQ-007 Port tx  output  1  UART serial line; idle high.
REQ-008 Port busy  output  1  high while a word is being transmitted.
REQ-009 Port done  output  1  one-cycle pulse at the end of the word.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY SHALL exist only when UART_TX_PARITY_EN is defined.
REQ-011 In IDLE, start=1 SHALL latch data into an internal LENGTH-bit shift register and enter START on the next edge.
REQ-012 start SHALL be ignored outside IDLE; data changes after the latch SHALL not affect the transmission.
REQ-013 The word SHALL be sent as LENGTH/8 byte frames, least-significant byte first.
REQ-014 Each frame: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1.
REQ-015 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every state change.
REQ-016 There SHALL be no idle gap between frames: the stop bit of byte k SHALL be followed directly by the start bit of byte k+1.
REQ-017 A byte counter SHALL track bytes sent; after the stop bit of byte LENGTH/8-1 the FSM SHALL return to IDLE.
REQ-018 tx SHALL be registered, SHALL go low in the first cycle after start is accepted, and SHALL be 1 in IDLE.
REQ-019 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-020 done SHALL be 1 for exactly the single cycle in which the FSM first re-enters IDLE, and 0 otherwise.
REQ-021 start=1 in the done cycle SHALL be accepted, giving back-to-back words separated by no idle bit.
REQ-022 Total latency from the start-accept edge to done SHALL be (LENGTH/8)*B*CLKS_PER_BIT cycles, where B=10 without parity and B=11 with parity.

Reset
REQ-023 While rst=0: FSM=IDLE, tx=1, busy=0, done=0, and all counters and the shift register SHALL be 0.
REQ-024 rst asserted mid-frame SHALL abort the transmission immediately and asynchronously; no partial byte SHALL resume after release.
REQ-025 The first start SHALL be accepted in the first cycle after rst is released.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 data bits) SHALL be sent between the last data bit and the stop bit; when undefined, no parity state or logic SHALL exist and frames SHALL be 10 bits.

Verification
REQ-027 CLKS_PER_BIT=4, LENGTH=32, data=32'h12345678, pulse start -> bytes 78,56,34,12 on tx; first frame bits 0,0,0,0,1,1,1,1,0,1, each 4 cycles; done 160 cycles after accept.
REQ-028 start held high during the transmission and data changed to 32'hFFFFFFFF mid-word -> original bytes are sent unchanged and exactly one done pulse occurs.
REQ-029 start=1 during the done cycle with data=32'h000000A5 -> the next start bit begins on the following cycle with no high gap; first byte A5 is sent LSB first as 1,0,1,0,0,1,0,1.
REQ-030 rst pulsed low at cycle 50 of a word -> tx=1 and busy=0 immediately, no done pulse; a new start after release transmits normally.
REQ-031 UART_TX_PARITY_EN defined, data byte 8'h07 -> parity bit 1; byte 8'h03 -> parity bit 0; done after 4*11*4=176 cycles.
REQ-032 LENGTH=8, data=8'h55 -> a single 10-bit frame, with done 40 cycles after accept.
